// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer block: FSM state encoding and the
// counter width calculation used by both the top and the counter sub-module.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOOT = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Counter must hold the larger of the cold-boot length and the frame length.
    function automatic int cnt_width(input int cold, input int full);
        int m;
        m = (cold > full) ? cold : full;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Up-counter for the timer: synchronous clear, load-to-1 and increment, with
// a terminal-count compare against a caller-supplied limit. The combinational
// next value is exported so the owner can register outputs derived from it.
module timer_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load_one,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count_next,
    output logic         at_limit
);

    logic [W-1:0] count;

    // Next-value selection: clear wins over load, load wins over increment.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (load_one) begin
            count_next = W'(1);
        end else if (inc) begin
            count_next = count + W'(1);
        end
    end

    // Count register; reset arrives through the clear input.
    always_ff @(posedge clk) begin
        count <= count_next;
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/timer.sv
// Enable-gated periodic waveform generator: after en rises, o stays low for
// COLD_BOOT_CYCLE cycles, then repeats a frame of FULL_CYCLE cycles whose first
// OUTPUT_UP_PERIOD cycles are high. Dropping en restarts from a full cold boot.
// Optional build macro TIMER_PERIOD_COUNT_EN adds a saturating 16-bit count of
// completed RUN frames on period_cnt.
module timer
    import timer_pkg::*;
#(
    parameter int COLD_BOOT_CYCLE  = 20,
    parameter int FULL_CYCLE       = 23,
    parameter int OUTPUT_UP_PERIOD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        o
`ifdef TIMER_PERIOD_COUNT_EN
    ,
    output logic [15:0] period_cnt
`endif
);

    localparam int W = cnt_width(COLD_BOOT_CYCLE, FULL_CYCLE);
    localparam logic [W-1:0] C_W = W'(COLD_BOOT_CYCLE);
    localparam logic [W-1:0] F_W = W'(FULL_CYCLE);
    localparam logic [W-1:0] U_W = W'(OUTPUT_UP_PERIOD);

    if ((FULL_CYCLE <= OUTPUT_UP_PERIOD) || (OUTPUT_UP_PERIOD < 1) || (COLD_BOOT_CYCLE < 0)) begin : g_bad_params
        $error("timer: illegal parameters (need FULL_CYCLE > OUTPUT_UP_PERIOD >= 1, COLD_BOOT_CYCLE >= 0)");
    end

    state_t       state;
    state_t       state_next;
    logic         cnt_clear;
    logic         cnt_load;
    logic         cnt_inc;
    logic [W-1:0] limit;
    logic [W-1:0] count_next;
    logic         at_limit;
    logic         o_next;

    // The counter ends a BOOT phase at the cold-boot length and a frame at the frame length.
    assign limit = (state == RUN) ? F_W : C_W;

    timer_counter #(
        .W(W)
    ) u_counter (
        .clk       (clk),
        .clear     (cnt_clear),
        .load_one  (cnt_load),
        .inc       (cnt_inc),
        .limit     (limit),
        .count_next(count_next),
        .at_limit  (at_limit)
    );

    // Next-state and counter commands; reset and a low enable both fall back to IDLE.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        if (!rst) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        cnt_load   = 1'b1;
                        state_next = (COLD_BOOT_CYCLE == 0) ? RUN : BOOT;
                    end else begin
                        cnt_clear = 1'b1;
                    end
                end
                BOOT: begin
                    if (!en) begin
                        state_next = IDLE;
                        cnt_clear  = 1'b1;
                    end else if (at_limit) begin
                        state_next = RUN;
                        cnt_load   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_next = IDLE;
                        cnt_clear  = 1'b1;
                    end else if (at_limit) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
    end

    // Output is high for the leading part of each frame, judged on the counter value being loaded.
    assign o_next = (state_next == RUN) && (count_next <= U_W);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            o     <= 1'b0;
        end else begin
            state <= state_next;
            o     <= o_next;
        end
    end

`ifdef TIMER_PERIOD_COUNT_EN
    logic frame_wrap;

    assign frame_wrap = rst && en && (state == RUN) && at_limit;

    // Completed-frame counter: saturates, and clears whenever the FSM heads back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst || (state_next == IDLE)) begin
            period_cnt <= 16'd0;
        end else if (frame_wrap && (period_cnt != 16'hFFFF)) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_timer.sv
// Directed bench for timer: default-parameter instance plus a C=0/F=3/U=1 corner
// instance. Period counter checks are active when TIMER_PERIOD_COUNT_EN is defined.
module tb_timer;

    logic clk;
    logic rst;
    logic en;
    logic o;
    logic rst_c;
    logic en_c;
    logic o_c;
`ifdef TIMER_PERIOD_COUNT_EN
    logic [15:0] period_cnt;
    logic [15:0] period_cnt_c;
`endif

    int total;
    int passed;

    timer dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .o         (o)
`ifdef TIMER_PERIOD_COUNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    timer #(
        .COLD_BOOT_CYCLE (0),
        .FULL_CYCLE      (3),
        .OUTPUT_UP_PERIOD(1)
    ) dut_c (
        .clk       (clk),
        .rst       (rst_c),
        .en        (en_c),
        .o         (o_c)
`ifdef TIMER_PERIOD_COUNT_EN
        ,
        .period_cnt(period_cnt_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected o after edge E0+n for cold boot c, frame f, high time u.
    function automatic logic expO(input int n, input int c, input int f, input int u);
        return (n >= c) && (((n - c) % f) < u);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got === exp) begin
            passed = passed + 1;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive both instances' inputs, then sample 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic r, input logic e, input logic rc, input logic ec);
        rst   = r;
        en    = e;
        rst_c = rc;
        en_c  = ec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b0;
        en     = 1'b0;
        rst_c  = 1'b0;
        en_c   = 1'b0;

        // Reset then idle with en low.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset o", 16'(o), 16'd0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("idle i=%0d", i), 16'(o), 16'd0);
        end

        // Cold boot and eight frames from E0.
        for (int n = 0; n < 204; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("frame n=%0d", n), 16'(o), 16'(expO(n, 20, 23, 16)));
`ifdef TIMER_PERIOD_COUNT_EN
            checkOutput($sformatf("period n=%0d", n), period_cnt,
                        16'((n >= 43) ? ((n - 43) / 23 + 1) : 0));
`endif
        end

        // Disable for three edges.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("disable i=%0d", i), 16'(o), 16'd0);
`ifdef TIMER_PERIOD_COUNT_EN
            checkOutput($sformatf("period clr i=%0d", i), period_cnt, 16'd0);
`endif
        end

        // Re-enable at E1: full cold boot again.
        for (int n = 0; n < 25; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("restart n=%0d", n), 16'(o), 16'(expO(n, 20, 23, 16)));
        end

        // A 10-cycle enable pulse never raises o.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pulse pre", 16'(o), 16'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("pulse i=%0d", i), 16'(o), 16'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pulse post", 16'(o), 16'd0);

        // Run into the high phase, then reset while o is high.
        for (int n = 0; n < 25; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("prerst n=%0d", n), 16'(o), 16'(expO(n, 20, 23, 16)));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("midrun reset o", 16'(o), 16'd0);
`ifdef TIMER_PERIOD_COUNT_EN
        checkOutput("midrun reset period", period_cnt, 16'd0);
`endif
        for (int n = 0; n < 22; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("postrst n=%0d", n), 16'(o), 16'(expO(n, 20, 23, 16)));
        end

        // Corner instance: no cold boot, 100 pattern.
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("corner n=%0d", n), 16'(o_c), 16'(expO(n, 0, 3, 1)));
`ifdef TIMER_PERIOD_COUNT_EN
            checkOutput($sformatf("corner period n=%0d", n), period_cnt_c, 16'(n / 3));
`endif
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("corner disable", 16'(o_c), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
